// File: rtl/mcu_el2_dccm_bank_init.sv
// mcu_el2_dccm_bank_init
// Sits between the core's exported DCCM bank signals and the physical DCCM
// SRAM banks. Core requests pass straight through, except while the
// sequencer is writing every word of every bank with zero data and zero ECC.
// All-zero is a valid SECDED codeword, so reads of any location after an
// initialisation never report a spurious ECC error.
//
// Optional build macro: MCU_DCCM_INIT_AUTO_EN
//   defined   -> initialisation starts on the first clock after reset release
//   undefined -> the block waits in IDLE for an init_req pulse
//
// Bus handshake: there is none. Every SRAM-side signal is a level that the
// SRAM samples each clock. A core access is "accepted" in any cycle where
// init_busy is low. While init_busy is high the core must stall, and any
// core clken seen in that window is recorded in init_collision.
module mcu_el2_dccm_bank_init #(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 32,
  parameter int ECC_W     = 7
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic                          init_req,
  input  logic [NUM_BANKS-1:0]          dccm_clken_in,
  input  logic [NUM_BANKS-1:0]          dccm_wren_in,
  input  logic [NUM_BANKS*ADDR_W-1:0]   dccm_addr_in,
  input  logic [NUM_BANKS*DATA_W-1:0]   dccm_wr_data_in,
  input  logic [NUM_BANKS*ECC_W-1:0]    dccm_wr_ecc_in,
  output logic [NUM_BANKS-1:0]          dccm_clken_out,
  output logic [NUM_BANKS-1:0]          dccm_wren_out,
  output logic [NUM_BANKS*ADDR_W-1:0]   dccm_addr_out,
  output logic [NUM_BANKS*DATA_W-1:0]   dccm_wr_data_out,
  output logic [NUM_BANKS*ECC_W-1:0]    dccm_wr_ecc_out,
  output logic                          init_busy,
  output logic                          init_done,
  output logic                          init_collision
);

  // Last word address of a bank; reaching it ends the sweep.
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Registered FSM state and sweep address; state_q is the debug view of
  // the sequencer for anyone probing the block.
  state_e             state_q;
  logic [ADDR_W-1:0]  addr_cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               coll_q;

  // Start request: an external pulse, or the one-shot post-reset trigger
  // when automatic initialisation is built in.
  logic start;
  logic core_any_clken;

  assign core_any_clken = |dccm_clken_in;

`ifdef MCU_DCCM_INIT_AUTO_EN
  // Set by reset, consumed by the first clock after reset release.
  logic auto_pend_q;

  // One-shot post-reset trigger.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      auto_pend_q <= 1'b1;
    end else begin
      auto_pend_q <= 1'b0;
    end
  end

  assign start = init_req | auto_pend_q;
`else
  assign start = init_req;
`endif

  // Sequencer FSM: owns state, sweep counter and all status flags.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= ST_IDLE;
      addr_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          // Core traffic is ignored here, but any attempt is remembered.
          if (core_any_clken) begin
            coll_q <= 1'b1;
          end
          // A repeated init_req is deliberately not looked at in this state.
          if (addr_cnt_q == ADDR_LAST) begin
            state_q    <= ST_DONE;
            addr_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            addr_cnt_q <= addr_cnt_q + 1'b1;
          end
        end
        default: begin
          // IDLE and DONE behave identically apart from the done flag.
          // A start clears a pending collision even if one is raised in
          // the same cycle, because collisions are only counted in INIT.
          if (start) begin
            state_q    <= ST_INIT;
            addr_cnt_q <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            coll_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign init_busy      = busy_q;
  assign init_done      = done_q;
  assign init_collision = coll_q;

  // Zero-latency SRAM-side mux: sweep values in INIT, core passthrough
  // otherwise. Only registered state selects, so there is no path from
  // init_req to the SRAM pins.
  logic sweep_sel;
  assign sweep_sel = (state_q == ST_INIT);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    // Per-bank output select.
    always_comb begin
      dccm_clken_out[b]                     = dccm_clken_in[b];
      dccm_wren_out[b]                      = dccm_wren_in[b];
      dccm_addr_out[b*ADDR_W +: ADDR_W]     = dccm_addr_in[b*ADDR_W +: ADDR_W];
      dccm_wr_data_out[b*DATA_W +: DATA_W]  = dccm_wr_data_in[b*DATA_W +: DATA_W];
      dccm_wr_ecc_out[b*ECC_W +: ECC_W]     = dccm_wr_ecc_in[b*ECC_W +: ECC_W];
      if (sweep_sel) begin
        dccm_clken_out[b]                    = 1'b1;
        dccm_wren_out[b]                     = 1'b1;
        dccm_addr_out[b*ADDR_W +: ADDR_W]    = addr_cnt_q;
        dccm_wr_data_out[b*DATA_W +: DATA_W] = '0;
        dccm_wr_ecc_out[b*ECC_W +: ECC_W]    = '0;
      end
    end
  end

endmodule

// File: tb/tb_mcu_el2_dccm_bank_init.sv
// Bench for mcu_el2_dccm_bank_init with 16-word banks. Directed cycles push
// the hand-derived SRAM-side image and status flags into queues; a monitor
// on the falling edge pops and compares each cycle.
module tb_mcu_el2_dccm_bank_init;

  localparam int NB    = 4;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int EW    = 7;
  localparam int DEPTH = 1 << AW;
  localparam int OW    = NB * 2 + NB * AW + NB * DW + NB * EW;

`ifdef MCU_DCCM_INIT_AUTO_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_l;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT ----------------
  logic                 init_req;
  logic [NB-1:0]        clken_in, wren_in, clken_out, wren_out;
  logic [NB*AW-1:0]     addr_in, addr_out;
  logic [NB*DW-1:0]     data_in, data_out;
  logic [NB*EW-1:0]     ecc_in, ecc_out;
  logic                 init_busy, init_done, init_collision;

  mcu_el2_dccm_bank_init #(
    .NUM_BANKS (NB),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .ECC_W     (EW)
  ) dut (
    .clk              (clk),
    .rst_l            (rst_l),
    .init_req         (init_req),
    .dccm_clken_in    (clken_in),
    .dccm_wren_in     (wren_in),
    .dccm_addr_in     (addr_in),
    .dccm_wr_data_in  (data_in),
    .dccm_wr_ecc_in   (ecc_in),
    .dccm_clken_out   (clken_out),
    .dccm_wren_out    (wren_out),
    .dccm_addr_out    (addr_out),
    .dccm_wr_data_out (data_out),
    .dccm_wr_ecc_out  (ecc_out),
    .init_busy        (init_busy),
    .init_done        (init_done),
    .init_collision   (init_collision)
  );

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  logic [2:0]    flg_q[$];
  int            n_checks = 0;
  int            n_fails  = 0;

  // Monitor: one SRAM image and one flag triple per driven cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && flg_q.size() > 0) begin
      logic [OW-1:0] e;
      logic [OW-1:0] a;
      logic [2:0]    f;
      logic [2:0]    fa;
      e  = exp_q.pop_front();
      f  = flg_q.pop_front();
      a  = {clken_out, wren_out, addr_out, data_out, ecc_out};
      fa = {init_busy, init_done, init_collision};
      n_checks++;
      if (a !== e) begin
        n_fails++;
        $display("FAIL sram_out t=%0t got=%h want=%h", $time, a, e);
      end
      n_checks++;
      if (fa !== f) begin
        n_fails++;
        $display("FAIL flags(busy,done,coll) t=%0t got=%b want=%b", $time, fa, f);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_core();
    clken_in = 4'($urandom_range(0, 15));
    wren_in  = 4'($urandom_range(0, 15));
    addr_in  = 16'($urandom_range(0, 65535));
    data_in  = {$urandom, $urandom, $urandom, $urandom};
    ecc_in   = 28'($urandom);
  endtask

  // Passthrough cycle: outputs must mirror the core inputs.
  task automatic pass_cycle(input bit rst, input bit req,
                            input bit b, input bit d, input bit c);
    @(posedge clk);
    #1;
    rst_l    = rst;
    init_req = req;
    drive_core();
    exp_q.push_back({clken_in, wren_in, addr_in, data_in, ecc_in});
    flg_q.push_back({b, d, c});
  endtask

  // Sweep cycle: all banks written with zero at address a; core clken is ck.
  task automatic init_cycle(input int a, input bit req,
                            input logic [NB-1:0] ck, input bit c);
    logic [AW-1:0] av;
    @(posedge clk);
    #1;
    init_req = req;
    drive_core();
    clken_in = ck;
    av = AW'(a);
    exp_q.push_back({4'hF, 4'hF, {NB{av}}, {(NB*DW){1'b0}}, {(NB*EW){1'b0}}});
    flg_q.push_back({1'b1, 1'b0, c});
  endtask

  task automatic full_sweep();
    for (int i = 0; i < DEPTH; i++) init_cycle(i, 1'b0, '0, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_l    = 1'b0;
    init_req = 1'b0;
    clken_in = '0;
    wren_in  = '0;
    addr_in  = '0;
    data_in  = '0;
    ecc_in   = '0;

    // Reset state: passthrough, all flags low.
    pass_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pass_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Release reset; this cycle still shows IDLE.
    pass_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    if (AUTO) begin
      // Sweep starts on its own on the first clock after release.
      full_sweep();
      pass_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    end else begin
      for (int i = 0; i < 6; i++) pass_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Plain initialisation: 16 sweep cycles then DONE with passthrough.
    pass_cycle(1'b1, 1'b1, 1'b0, AUTO, 1'b0);
    full_sweep();
    for (int i = 0; i < 3; i++) pass_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Repeated init_req mid-sweep is ignored: addresses continue, 16 total.
    pass_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) init_cycle(i, (i == 5), '0, 1'b0);
    pass_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Collision at sweep address 3: outputs untouched, flag sticky.
    pass_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      init_cycle(i, 1'b0, (i == 3) ? 4'b0010 : 4'b0000, (i > 3));
    for (int i = 0; i < 3; i++) pass_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    // Next init_req clears the collision.
    pass_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    full_sweep();
    pass_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset during the ninth sweep cycle: immediate passthrough, flags clear.
    pass_cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) init_cycle(i, 1'b0, '0, 1'b0);
    pass_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pass_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pass_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    if (AUTO) begin
      full_sweep();
      pass_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    end else begin
      for (int i = 0; i < 3; i++) pass_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain got=%0d want=0 pending", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mcu_el2_dccm_bank_init.md
Name: mcu_el2_dccm_bank_init

Overview:
- Sits on the DCCM bank interface, directly downstream of the core memory block's exported DCCM bank signals and upstream of the physical DCCM SRAM banks.
- Passes core bank requests through to the SRAMs unchanged.
- On request, runs a sequencer that writes every word of every bank with zero data and zero ECC. All-zero is a valid SECDED codeword, so later reads do not raise spurious ECC errors.
- Read data and read ECC go straight from SRAM to core and do not pass through this block.

Parameters:
- NUM_BANKS, 4, number of DCCM banks.
- ADDR_W, 14, per-bank word address width; DEPTH = 2**ADDR_W.
- DATA_W, 32, data bits per bank word.
- ECC_W, 7, ECC bits per bank word.

Ports:
- clk  input  1  core clock.
- rst_l  input  1  reset; asynchronous, active-low.
- init_req  input  1  single-cycle pulse requesting a full-array initialisation.
- dccm_clken_in  input  NUM_BANKS  core per-bank clock enable/request.
- dccm_wren_in  input  NUM_BANKS  core per-bank write enable.
- dccm_addr_in  input  NUM_BANKS*ADDR_W  core per-bank address, bank b at [b*ADDR_W +: ADDR_W].
- dccm_wr_data_in  input  NUM_BANKS*DATA_W  core per-bank write data.
- dccm_wr_ecc_in  input  NUM_BANKS*ECC_W  core per-bank write ECC.
- dccm_clken_out  output  NUM_BANKS  SRAM clock enable.
- dccm_wren_out  output  NUM_BANKS  SRAM write enable.
- dccm_addr_out  output  NUM_BANKS*ADDR_W  SRAM address.
- dccm_wr_data_out  output  NUM_BANKS*DATA_W  SRAM write data.
- dccm_wr_ecc_out  output  NUM_BANKS*ECC_W  SRAM write ECC.
- init_busy  output  1  sequencer owns the SRAMs; core must stall DCCM accesses.
- init_done  output  1  last initialisation completed.
- init_collision  output  1  sticky: the core asserted a clken while init_busy.

Behaviour:
- State machine: IDLE, INIT, DONE. State, counter and flags are registered; SRAM-side outputs are a combinational mux selected by registered state.
- Reset values (async on rst_l low): state IDLE, addr_cnt 0, init_busy 0, init_done 0, init_collision 0.
- Reset has no effect on SRAM-side outputs beyond the state mux: in IDLE they equal the core inputs.
- IDLE, DONE:
  - All *_out equal the corresponding *_in, bit for bit, combinationally (zero latency).
  - init_req=1 -> next cycle INIT, addr_cnt=0, init_busy=1, init_done=0, init_collision=0.
- INIT:
  - dccm_clken_out and dccm_wren_out are all ones.
  - Every bank's address = addr_cnt; wr_data and wr_ecc are all zero.
  - Core inputs are ignored.
  - addr_cnt increments by 1 each cycle.
  - When addr_cnt == DEPTH-1, that write issues and the next cycle enters DONE with init_done=1, init_busy=0, addr_cnt=0.
  - INIT therefore lasts exactly DEPTH cycles. Writes to addresses 0..DEPTH-1 each occur once, with no wrap.
- init_busy is 1 exactly in INIT.
- init_req during INIT is ignored: no restart and no counter change.
- init_collision:
  - Set in any INIT cycle where |dccm_clken_in == 1.
  - Holds until the next accepted init_req or reset.
  - An init_req accepted in the same cycle as a collision clears it (start takes priority, since that cycle is in IDLE/DONE).
- init_done:
  - Holds in DONE until the next accepted init_req or reset.
  - DONE otherwise behaves as IDLE.
- Reset mid-INIT: immediate return to IDLE; init_done stays 0; the partially written array is not flagged.

Optional Feature:
- Macro: MCU_DCCM_INIT_AUTO_EN.
- Defined:
  - First clock after rst_l deasserts, the FSM enters INIT as if init_req had been pulsed.
  - init_busy rises that cycle.
  - init_req is still honoured afterwards.
- Undefined: the FSM stays in IDLE after reset until init_req.

Test Plan:
- ADDR_W=4, NUM_BANKS=4, macro undefined. Reset, then drive random core requests in IDLE -> every *_out matches *_in each cycle; init_busy=0, init_done=0.
- Pulse init_req at cycle N -> cycles N+1..N+16: clken_out=wren_out=4'b1111, addresses 0..15 in order, data and ECC zero. Cycle N+17: init_busy=0, init_done=1, passthrough restored.
- Pulse init_req again at INIT cycle 5 -> ignored; addr_cnt continues 6,7,..., and INIT still ends after 16 total cycles.
- Assert dccm_clken_in=4'b0010 during INIT cycle 3 -> SRAM outputs unaffected; init_collision=1 after INIT and stays set; the next init_req clears it.
- Drop rst_l during INIT cycle 8 -> outputs return to passthrough immediately; init_busy=0, init_done=0, state IDLE.
- With MCU_DCCM_INIT_AUTO_EN defined, release reset with no init_req -> INIT starts on the first clock; init_done=1 after 16 write cycles.
